// File: rtl/rs_collapse_mp.sv
// rs_collapse_mp -- parametrised collapsing-queue reservation station.
//
// Holds up to DEPTH uops in age order (index 0 is the oldest). Each entry
// tracks NSRC operand-ready bits that are set by wakeup broadcasts. Entries are
// removed when they are granted, when a mispredict kills them, or on flush.
// Every cycle the queue is rebuilt: survivors keep their order and are packed
// from index 0, and the dispatch lanes are appended behind them.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   stall              freeze all state; issue requests forced low
//   flush              invalidate every entry (ovf_err is kept)
//   kill_en/kill_clr   branch resolution against the one-hot br_spectag
//   disp_*             DISP dispatch lanes, flattened with lane l at slice l
//   wk_valid/wk_tag    WK wakeup broadcast ports
//   iss_req/payload/dst_tag/idx  ISS issue request ports (oldest ready first)
//   iss_grant          same-cycle confirmation of iss_req
//   free_cnt           registered count of invalid entries
//   ovf_err            sticky flag: dispatch tried to exceed capacity
module rs_collapse_mp #(
   parameter int DEPTH     = 8,
   parameter int DISP      = 2,
   parameter int ISS       = 2,
   parameter int WK        = 4,
   parameter int NSRC      = 2,
   parameter int TAG_W     = 7,
   parameter int SPEC_W    = 4,
   parameter int CLS_W     = 4,
   parameter int PAYLOAD_W = 64,
   parameter int WINDOW    = DEPTH,
   parameter logic [ISS*CLS_W-1:0] PORT_CLS = '1,
   parameter int FAST_WAKE = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic                              flush,
   input  logic                              kill_en,
   input  logic                              kill_clr,
   input  logic [SPEC_W-1:0]                 br_spectag,
   input  logic [DISP-1:0]                   disp_valid,
   input  logic [DISP*PAYLOAD_W-1:0]         disp_payload,
   input  logic [DISP*NSRC*TAG_W-1:0]        disp_src_tag,
   input  logic [DISP*NSRC-1:0]              disp_src_rdy,
   input  logic [DISP*TAG_W-1:0]             disp_dst_tag,
   input  logic [DISP-1:0]                   disp_dst_we,
   input  logic [DISP-1:0]                   disp_single,
   input  logic [DISP*SPEC_W-1:0]            disp_killmask,
   input  logic [DISP*CLS_W-1:0]             disp_cls,
   input  logic [WK-1:0]                     wk_valid,
   input  logic [WK*TAG_W-1:0]               wk_tag,
   output logic [ISS-1:0]                    iss_req,
   output logic [ISS*PAYLOAD_W-1:0]          iss_payload,
   output logic [ISS*TAG_W-1:0]              iss_dst_tag,
   output logic [ISS*$clog2(DEPTH)-1:0]      iss_idx,
   input  logic [ISS-1:0]                    iss_grant,
   output logic [$clog2(DEPTH):0]            free_cnt,
   output logic                              ovf_err
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int FREE_W = IDX_W + 1;

   typedef struct packed {
      logic [PAYLOAD_W-1:0]         payload;
      logic [NSRC-1:0][TAG_W-1:0]   src_tag;
      logic [NSRC-1:0]              src_rdy;
      logic [TAG_W-1:0]             dst_tag;
      logic                         dst_we;
      logic                         single;
      logic [SPEC_W-1:0]            killmask;
      logic [CLS_W-1:0]             cls;
   } entry_t;

   entry_t               ent_r     [DEPTH];
   logic [DEPTH-1:0]     valid_r;
   logic [FREE_W-1:0]    free_cnt_r;
   logic                 ovf_err_r;

   entry_t               nxt_ent_s [DEPTH];
   logic [DEPTH-1:0]     nxt_valid_s;
   logic [FREE_W-1:0]    ptr_s;
   logic                 ovf_s;
   logic [DEPTH-1:0]     elig_s;
   logic [DEPTH-1:0]     taken_s;
   logic [DEPTH-1:0]     grant_s;
   logic [ISS-1:0]       iss_req_s;
   logic [IDX_W-1:0]     sel_idx_s [ISS];
   logic [ISS-1:0]       fw_valid_s;
   logic [ISS*TAG_W-1:0] fw_tag_s;

   // True when tag t matches any valid wakeup port or any fast-wake source.
   function automatic logic tag_hit(input logic [TAG_W-1:0]     t,
                                    input logic [WK-1:0]        wv,
                                    input logic [WK*TAG_W-1:0]  wt,
                                    input logic [ISS-1:0]       fv,
                                    input logic [ISS*TAG_W-1:0] ft);
      logic h;
      h = 1'b0;
      for (int w = 0; w < WK; w++) begin
         h = h | (wv[w] & (wt[w*TAG_W +: TAG_W] == t));
      end
      for (int k = 0; k < ISS; k++) begin
         h = h | (fv[k] & (ft[k*TAG_W +: TAG_W] == t));
      end
      return h;
   endfunction

   // True when a kill mask depends on the branch being killed this cycle.
   function automatic logic is_killed(input logic [SPEC_W-1:0] km,
                                      input logic              ken,
                                      input logic [SPEC_W-1:0] tag);
      return ken & (|(km & tag));
   endfunction

   // Issue select: each port takes the oldest eligible entry of an accepted
   // class that a lower-numbered port has not already taken. Also derives the
   // per-entry grant vector and the fast-wake tags of granted uops.
   always_comb begin
      taken_s    = '0;
      grant_s    = '0;
      iss_req_s  = '0;
      fw_valid_s = '0;
      fw_tag_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         elig_s[i] = valid_r[i] & (&ent_r[i].src_rdy) & (i < WINDOW);
      end
      for (int k = 0; k < ISS; k++) begin
         logic found;
         found        = 1'b0;
         sel_idx_s[k] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (!found && elig_s[i] && !taken_s[i] &&
                (|(ent_r[i].cls & PORT_CLS[k*CLS_W +: CLS_W]))) begin
               found        = 1'b1;
               taken_s[i]   = 1'b1;
               sel_idx_s[k] = IDX_W'(i);
            end else begin
               found = found;
            end
         end
         iss_req_s[k] = found & ~stall;
         grant_s[sel_idx_s[k]] = grant_s[sel_idx_s[k]] | (iss_req_s[k] & iss_grant[k]);
         fw_valid_s[k] = (FAST_WAKE != 0) & iss_req_s[k] & iss_grant[k] &
                         ent_r[sel_idx_s[k]].dst_we & ent_r[sel_idx_s[k]].single;
         fw_tag_s[k*TAG_W +: TAG_W] = ent_r[sel_idx_s[k]].dst_tag;
      end
   end

   // Drive the issue ports from the selected entries.
   always_comb begin
      iss_req     = iss_req_s;
      iss_payload = '0;
      iss_dst_tag = '0;
      iss_idx     = '0;
      for (int k = 0; k < ISS; k++) begin
         iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = ent_r[sel_idx_s[k]].payload;
         iss_dst_tag[k*TAG_W +: TAG_W]         = ent_r[sel_idx_s[k]].dst_tag;
         iss_idx[k*IDX_W +: IDX_W]             = sel_idx_s[k];
      end
   end

   // Next-state queue: apply wakeup, kill and kill-clear to entries and lanes,
   // then pack survivors from index 0 followed by surviving lanes in order.
   // ptr_s is the next free slot and ends as the occupied count.
   always_comb begin
      nxt_valid_s = '0;
      ptr_s       = '0;
      ovf_s       = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         nxt_ent_s[i] = ent_r[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         entry_t e;
         e = ent_r[i];
         for (int s = 0; s < NSRC; s++) begin
            e.src_rdy[s] = e.src_rdy[s] |
                           tag_hit(e.src_tag[s], wk_valid, wk_tag, fw_valid_s, fw_tag_s);
         end
         e.killmask = kill_clr ? (e.killmask & ~br_spectag) : e.killmask;
         if (valid_r[i] && !grant_s[i] &&
             !is_killed(ent_r[i].killmask, kill_en, br_spectag)) begin
            nxt_ent_s[ptr_s[IDX_W-1:0]]   = e;
            nxt_valid_s[ptr_s[IDX_W-1:0]] = 1'b1;
            ptr_s = ptr_s + FREE_W'(1);
         end else begin
            ptr_s = ptr_s;
         end
      end
      for (int l = 0; l < DISP; l++) begin
         entry_t e;
         e.payload  = disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
         e.dst_tag  = disp_dst_tag[l*TAG_W +: TAG_W];
         e.dst_we   = disp_dst_we[l];
         e.single   = disp_single[l];
         e.cls      = disp_cls[l*CLS_W +: CLS_W];
         e.killmask = disp_killmask[l*SPEC_W +: SPEC_W];
         for (int s = 0; s < NSRC; s++) begin
            e.src_tag[s] = disp_src_tag[(l*NSRC+s)*TAG_W +: TAG_W];
            e.src_rdy[s] = disp_src_rdy[l*NSRC+s] |
                           tag_hit(e.src_tag[s], wk_valid, wk_tag, fw_valid_s, fw_tag_s);
         end
         e.killmask = kill_clr ? (e.killmask & ~br_spectag) : e.killmask;
         if (disp_valid[l] &&
             !is_killed(disp_killmask[l*SPEC_W +: SPEC_W], kill_en, br_spectag)) begin
            if (ptr_s < FREE_W'(DEPTH)) begin
               nxt_ent_s[ptr_s[IDX_W-1:0]]   = e;
               nxt_valid_s[ptr_s[IDX_W-1:0]] = 1'b1;
               ptr_s = ptr_s + FREE_W'(1);
            end else begin
               // no room: the youngest lanes are the ones dropped
               ovf_s = 1'b1;
            end
         end else begin
            ovf_s = ovf_s;
         end
      end
   end

   // State update with priority rst > flush > stall > normal.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r    <= '0;
         free_cnt_r <= FREE_W'(DEPTH);
         ovf_err_r  <= 1'b0;
      end else if (flush) begin
         valid_r    <= '0;
         free_cnt_r <= FREE_W'(DEPTH);
      end else if (!stall) begin
         valid_r    <= nxt_valid_s;
         free_cnt_r <= FREE_W'(DEPTH) - ptr_s;
         ovf_err_r  <= ovf_err_r | ovf_s;
         for (int i = 0; i < DEPTH; i++) begin
            ent_r[i] <= nxt_ent_s[i];
         end
      end
   end

   assign free_cnt = free_cnt_r;
   assign ovf_err  = ovf_err_r;

endmodule
